dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the CPU's load/store port.
- Accepts one request at a time through a valid/ready handshake and inserts a configurable number of wait states.
- Performs word, halfword or byte reads/writes on an internal little-endian word array, and returns read data (sign- or zero-extended) plus an error flag through a valid/ready response channel.
- Sits beside the datapath; replaces the single-cycle data memory once the pipeline gains stall support.

Parameters:
ADDR_WIDTH, 10, word-address bits; array holds 2^ADDR_WIDTH 32-bit words.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word aligned.
WAIT_CYCLES, 2, wait states between request acceptance and response (0..15).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data, right-aligned for byte/half.
req_byte  input  1  byte access.
req_half  input  1  halfword access; ignored when req_byte = 1.
req_signed  input  1  load result sign-extended when 1, zero-extended when 0.
resp_valid  output  1  response present.
resp_ready  input  1  requester consumes response.
resp_rdata  output  32  load result; 0 for stores and errors.
resp_err  output  1  misaligned or out-of-range access.

Behaviour:
- Reset (reset = 0 at an edge):
  - State returns to IDLE; wait counter cleared.
  - resp_valid, resp_err and resp_rdata go to 0.
  - Memory array is not cleared.
  - req_ready = (state == IDLE) && reset, so it is 0 while reset is held.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready = 1. On req_valid && req_ready, latch we/addr/wdata/byte/half/signed, load counter = WAIT_CYCLES, go to WAIT.
  - WAIT: req_ready = 0. If counter == 0: commit the access, register resp_rdata/resp_err, set resp_valid = 1, go to RESP. Else decrement counter.
  - RESP: resp_valid = 1; outputs held stable. On resp_ready = 1, clear resp_valid/resp_err/resp_rdata and go to IDLE. A new request is accepted no earlier than the cycle after returning to IDLE (no back-to-back overlap).
- Latency: request accepted at edge E0 → resp_valid high after edge E0 + WAIT_CYCLES + 1. With WAIT_CYCLES = 0 this is 1 cycle.
- Address decode:
  - off = req_addr - BASE_ADDR; word index = off[ADDR_WIDTH+1:2]; lane = off[1:0].
  - Out of range: req_addr < BASE_ADDR, or off ≥ 4·2^ADDR_WIDTH (computed without 32-bit wrap).
  - Misaligned: word with lane ≠ 0; half with lane[0] = 1.
  - Either condition → resp_err = 1, resp_rdata = 0, no memory write.
- Stores (committed only at the WAIT→RESP edge):
  - Byte: mem[idx][8·lane+7 : 8·lane] = wdata[7:0].
  - Half: mem[idx][16·lane[1]+15 : 16·lane[1]] = wdata[15:0].
  - Word: whole word.
  - Untouched bytes are preserved. resp_rdata = 0.
- Loads: extract the same byte/half/word field; extend to 32 bits per req_signed (word ignores it).
- Reset during WAIT: request abandoned, no write.
- Reset during RESP: write already committed; response dropped.
- Request inputs are ignored outside IDLE; a held req_valid is accepted on the first IDLE cycle.
- resp_ready outside RESP is ignored.

Test Plan:
- WAIT_CYCLES = 2. Store word 32'hDEADBEEF @0x10, then load word @0x10 → resp_valid rises exactly 3 cycles after each acceptance; load resp_rdata = 32'hDEADBEEF, resp_err = 0.
- After the above: store byte 8'h80 @0x11, then load byte signed @0x11 → 32'hFFFFFF80. Load byte unsigned → 32'h00000080. Load word @0x10 → 32'hDEAD80EF.
- Store half 16'h1234 @0x12, load half unsigned @0x12 → 32'h00001234. Load half @0x13 → resp_err = 1, rdata = 0. Store word @0x12 → resp_err = 1 and word @0x10 unchanged.
- ADDR_WIDTH = 10: load @0x1000 → resp_err = 1. Load @0x0FFC → resp_err = 0.
- Hold resp_ready = 0 for 5 cycles in RESP → resp_valid/rdata stable and req_ready = 0 throughout. Assert resp_ready → IDLE next cycle, req_ready = 1.
- Store to 0x20 with reset pulsed low during WAIT → no response, req_ready = 0 during reset. A later load @0x20 returns the prior contents. Repeat with WAIT_CYCLES = 0 → latency 1 cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with configurable
// wait states over a little-endian 32-bit word array.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_byte,
   input  logic        req_half,
   input  logic        req_signed,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam logic [33:0] LIMIT = 34'd4 << ADDR_WIDTH;

   state_t state, next_state;
   logic [3:0]  count;
   logic        accept, commit, resp_done;

   logic        lat_we, lat_byte, lat_half, lat_signed;
   logic [31:0] lat_addr, lat_wdata;

   logic [31:0] off;
   logic [1:0]  lane;
   logic [ADDR_WIDTH-1:0] idx;
   logic        is_half, below, beyond, misaligned, acc_err;

   logic [31:0] mem [DEPTH];
   logic [31:0] cur_word, load_val, wrep, store_word;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [3:0]  wmask;

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      commit     = 1'b0;
      resp_done  = 1'b0;
      unique case (state)
         ST_IDLE: if (req_valid) begin
            accept     = 1'b1;
            next_state = ST_WAIT;
         end
         ST_WAIT: if (count == '0) begin
            commit     = 1'b1;
            next_state = ST_RESP;
         end
         ST_RESP: if (resp_ready) begin
            resp_done  = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign req_ready  = (state == ST_IDLE) && reset;
   assign resp_valid = (state == ST_RESP);

   // Range check is done in 34 bits so the upper bound cannot wrap.
   always_comb begin
      off        = lat_addr - BASE_ADDR;
      lane       = off[1:0];
      idx        = off[ADDR_WIDTH+1:2];
      below      = lat_addr < BASE_ADDR;
      beyond     = {2'b00, off} >= LIMIT;
      is_half    = !lat_byte && lat_half;
      misaligned = lat_byte ? 1'b0 : (is_half ? lane[0] : (lane != 2'b00));
      acc_err    = below || beyond || misaligned;
   end

   always_comb begin
      cur_word = mem[idx];
      sel_byte = cur_word[{lane, 3'b000} +: 8];
      sel_half = lane[1] ? cur_word[31:16] : cur_word[15:0];
      if (lat_byte)     load_val = {{24{lat_signed & sel_byte[7]}}, sel_byte};
      else if (is_half) load_val = {{16{lat_signed & sel_half[15]}}, sel_half};
      else              load_val = cur_word;
   end

   // Store data is replicated across lanes; the byte mask picks which survive.
   always_comb begin
      if (lat_byte) begin
         wrep  = {4{lat_wdata[7:0]}};
         wmask = 4'b0001 << lane;
      end else if (is_half) begin
         wrep  = {2{lat_wdata[15:0]}};
         wmask = lane[1] ? 4'b1100 : 4'b0011;
      end else begin
         wrep  = lat_wdata;
         wmask = 4'b1111;
      end
      store_word = cur_word;
      for (int unsigned i = 0; i < 4; i++) begin
         if (wmask[i]) store_word[8*i +: 8] = wrep[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset && commit && lat_we && !acc_err) mem[idx] <= store_word;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count      <= '0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         if (accept) begin
            lat_we     <= req_we;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_byte   <= req_byte;
            lat_half   <= req_half;
            lat_signed <= req_signed;
            count      <= 4'(WAIT_CYCLES);
         end else if (state == ST_WAIT && count != '0) begin
            count <= count - 4'd1;
         end
         if (commit) begin
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || lat_we) ? '0 : load_val;
         end else if (resp_done) begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written reset/stall
// sequences and random traffic against a byte-addressed reference model.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid [2], req_ready [2], req_we [2];
   logic        req_byte [2], req_half [2], req_signed [2];
   logic        resp_valid [2], resp_ready [2], resp_err [2];
   logic [31:0] req_addr [2], req_wdata [2], resp_rdata [2];

   dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_byte(req_byte[0]),
      .req_half(req_half[0]), .req_signed(req_signed[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   dmem_responder #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_byte(req_byte[1]),
      .req_half(req_half[1]), .req_signed(req_signed[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   int errors = 0;
   int checks = 0;

   // Reference memory: one entry per written byte, keyed by unit and byte offset.
   logic [7:0] mdl [longint];

   function automatic int wait_of(input int u);
      return (u == 0) ? 2 : 0;
   endfunction
   function automatic logic [31:0] base_of(input int u);
      return (u == 0) ? 32'h0000_0000 : 32'h0000_0100;
   endfunction
   function automatic int aw_of(input int u);
      return (u == 0) ? 10 : 4;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic model(input int u, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic b, input logic h, input logic s,
                        output logic [31:0] rd, output logic er, output logic known);
      longint off, key;
      int size;
      logic [31:0] v;
      off   = longint'(addr) - longint'(base_of(u));
      size  = b ? 1 : (h ? 2 : 4);
      v     = '0;
      rd    = '0;
      known = 1'b1;
      er    = (off < 0) || (off >= (longint'(4) << aw_of(u))) || ((off % size) != 0);
      if (er) return;
      key = longint'(u) * 64'h1_0000_0000 + off;
      if (we) begin
         for (int k = 0; k < size; k++) mdl[key + k] = wdata[8*k +: 8];
      end else begin
         for (int k = 0; k < size; k++) begin
            if (mdl.exists(key + k)) v[8*k +: 8] = mdl[key + k];
            else known = 1'b0;
         end
         if (s && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
         rd = v;
      end
   endtask

   task automatic txn(input int u, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic b, input logic h, input logic s,
                      input int hold, input logic use_tab, input logic [31:0] t_rd,
                      input logic t_er, input string nm);
      logic [31:0] m_rd, e_rd;
      logic m_er, e_er, known;
      int n, lat;
      model(u, we, addr, wdata, b, h, s, m_rd, m_er, known);
      if (use_tab) begin e_rd = t_rd; e_er = t_er; known = 1'b1; end
      else         begin e_rd = m_rd; e_er = m_er; end
      req_we[u] = we; req_addr[u] = addr; req_wdata[u] = wdata;
      req_byte[u] = b; req_half[u] = h; req_signed[u] = s; req_valid[u] = 1'b1;
      n = 0;
      while (!req_ready[u] && n < 20) begin @(posedge clk); #1; n++; end
      chk({nm, " accept"}, 32'(req_ready[u]), 32'd1);
      if (!req_ready[u]) begin req_valid[u] = 1'b0; return; end
      @(posedge clk); #1;
      // junk on the request bus while busy must be ignored
      req_valid[u] = 1'b0; req_addr[u] = $urandom; req_wdata[u] = $urandom;
      req_we[u] = 1'($urandom_range(0, 1));
      lat = 0;
      while (!resp_valid[u] && lat < 40) begin @(posedge clk); #1; lat++; end
      chk({nm, " latency"}, 32'(lat), 32'(wait_of(u) + 1));
      chk({nm, " err"}, 32'(resp_err[u]), 32'(e_er));
      if (known) chk({nm, " rdata"}, resp_rdata[u], e_rd);
      chk({nm, " busy"}, 32'(req_ready[u]), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({nm, " hold"}, 32'({resp_valid[u], req_ready[u], resp_err[u]}), 32'({2'b10, e_er}));
         if (known) chk({nm, " hold rdata"}, resp_rdata[u], e_rd);
      end
      resp_ready[u] = 1'b1;
      @(posedge clk); #1;
      resp_ready[u] = 1'b0;
      chk({nm, " done"}, 32'({resp_valid[u], req_ready[u], resp_err[u]}), 32'b010);
      chk({nm, " done rdata"}, resp_rdata[u], 32'd0);
   endtask

   task automatic rst_in_wait(input int u, input logic [31:0] addr, input logic [31:0] wdata,
                              input string nm);
      int n;
      logic seen;
      req_we[u] = 1'b1; req_addr[u] = addr; req_wdata[u] = wdata;
      req_byte[u] = 1'b0; req_half[u] = 1'b0; req_signed[u] = 1'b0; req_valid[u] = 1'b1;
      n = 0;
      while (!req_ready[u] && n < 20) begin @(posedge clk); #1; n++; end
      chk({nm, " accept"}, 32'(req_ready[u]), 32'd1);
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      chk({nm, " ready in reset"}, 32'(req_ready[u]), 32'd0);
      chk({nm, " valid in reset"}, 32'(resp_valid[u]), 32'd0);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (resp_valid[u]) seen = 1'b1;
      end
      chk({nm, " no response"}, 32'(seen), 32'd0);
      chk({nm, " idle"}, 32'(req_ready[u]), 32'd1);
   endtask

   typedef struct {
      int          u;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        b, h, s;
      logic [31:0] rd;
      logic        er;
   } vec_t;

   vec_t tab [27];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int u, r;
      logic [31:0] a;
      tab[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
      tab[1]  = '{0, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
      tab[2]  = '{0, 1'b1, 32'h11,  32'h80,       1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
      tab[3]  = '{0, 1'b0, 32'h11,  32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0};
      tab[4]  = '{0, 1'b0, 32'h11,  32'h0,        1'b1, 1'b0, 1'b0, 32'h00000080, 1'b0};
      tab[5]  = '{0, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 1'b0, 32'hDEAD80EF, 1'b0};
      tab[6]  = '{0, 1'b1, 32'h12,  32'h1234,     1'b0, 1'b1, 1'b0, 32'h0,        1'b0};
      tab[7]  = '{0, 1'b0, 32'h12,  32'h0,        1'b0, 1'b1, 1'b0, 32'h00001234, 1'b0};
      tab[8]  = '{0, 1'b0, 32'h13,  32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b1};
      tab[9]  = '{0, 1'b1, 32'h12,  32'hCAFEBABE, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
      tab[10] = '{0, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 1'b0, 32'h123480EF, 1'b0};
      tab[11] = '{0, 1'b0, 32'h1000, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
      tab[12] = '{0, 1'b1, 32'hFFC, 32'hA5A50F0F, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
      tab[13] = '{0, 1'b0, 32'hFFC, 32'h0,        1'b0, 1'b0, 1'b0, 32'hA5A50F0F, 1'b0};
      tab[14] = '{0, 1'b0, 32'hFFFFFFFC, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
      tab[15] = '{0, 1'b1, 32'h20,  32'h55AA33CC, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
      tab[16] = '{0, 1'b0, 32'h22,  32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFFFAA, 1'b0};
      tab[17] = '{0, 1'b0, 32'h21,  32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b1};
      tab[18] = '{0, 1'b1, 32'h13,  32'hFF,       1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
      tab[19] = '{0, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 1'b1, 32'hFF3480EF, 1'b0};
      tab[20] = '{1, 1'b1, 32'h104, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0};
      tab[21] = '{1, 1'b0, 32'h106, 32'h0,        1'b0, 1'b1, 1'b1, 32'hFFFFCAFE, 1'b0};
      tab[22] = '{1, 1'b0, 32'hFC,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
      tab[23] = '{1, 1'b0, 32'h140, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
      tab[24] = '{1, 1'b1, 32'h13F, 32'h7F,       1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
      tab[25] = '{1, 1'b0, 32'h13F, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000007F, 1'b0};
      tab[26] = '{1, 1'b0, 32'h104, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000000D, 1'b0};

      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
         req_byte[i] = 1'b0; req_half[i] = 1'b0; req_signed[i] = 1'b0; resp_ready[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset ready", 32'(req_ready[i]), 32'd0);
         chk("reset valid", 32'(resp_valid[i]), 32'd0);
         chk("reset err", 32'(resp_err[i]), 32'd0);
         chk("reset rdata", resp_rdata[i], 32'd0);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      chk("post-reset ready0", 32'(req_ready[0]), 32'd1);
      chk("post-reset ready1", 32'(req_ready[1]), 32'd1);

      for (int i = 0; i < 27; i++) begin
         txn(tab[i].u, tab[i].we, tab[i].addr, tab[i].wdata, tab[i].b, tab[i].h, tab[i].s,
             0, 1'b1, tab[i].rd, tab[i].er, $sformatf("vec%0d", i));
      end

      txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 5, 1'b1, 32'hFF3480EF, 1'b0, "stall");
      rst_in_wait(0, 32'h20, 32'h11111111, "rst_wait0");
      txn(0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h55AA33CC, 1'b0, "after rst0");
      rst_in_wait(1, 32'h104, 32'h0, "rst_wait1");
      txn(1, 1'b0, 32'h104, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'hCAFEF00D, 1'b0, "after rst1");

      for (int i = 0; i < 64; i += 4) begin
         txn(0, 1'b1, 32'(i), $urandom, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, "fill0");
         txn(1, 1'b1, 32'h100 + 32'(i), $urandom, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, "fill1");
      end
      txn(0, 1'b1, 32'hFF8, $urandom, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, 1'b0, "fill0 top");

      for (int i = 0; i < 300; i++) begin
         u = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         if (r < 7)      a = base_of(u) + 32'($urandom_range(0, 63));
         else if (r < 9) a = base_of(u) + 32'((4 << aw_of(u)) - 8) + 32'($urandom_range(0, 15));
         else            a = $urandom;
         txn(u, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
             1'b0, '0, 1'b0, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
